alu_share_arbiter: RTL
======================

# alu_share_arbiter

Two-port arbiter and sequencer that shares the single combinational `alu` between two requesters, e.g. the execute stage and an address-generation unit. It accepts one operation at a time over valid/ready, drives registered operands and `alu_control` onto the ALU, captures `alu_result`/`zero` one cycle later, and returns the result on the winning requester's response channel. It sits between the requesters and the ALU instance; the ALU itself stays outside this block.

## Interface
- `WIDTH`, default `` `WORD `` — operand/result width.
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req0_valid` in 1 / `req0_ready` out 1 — requester 0 handshake.
- `req0_a`, `req0_b` in WIDTH — requester 0 operands.
- `req0_op` in 4 — requester 0 ALU control code (`` `ALU_* ``).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op` — same for requester 1.
- `rsp0_valid` out 1 / `rsp0_ready` in 1 — requester 0 response handshake.
- `rsp1_valid` out 1 / `rsp1_ready` in 1 — requester 1 response handshake.
- `rsp_result` out WIDTH — captured ALU result, shared by both response channels.
- `rsp_zero` out 1 — captured zero flag.
- `alu_a`, `alu_b` out WIDTH — registered operands to the ALU `a_in`/`b_in`.
- `alu_ctrl` out 4 — registered control to ALU `alu_control`.
- `alu_res` in WIDTH, `alu_zero` in 1 — from ALU `alu_result`/`zero`.
- `busy` out 1 — high in EXEC or RESP.

## Operation
- FSM: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Grant is computed combinationally from the valids.
  - `reqN_ready` = (state==IDLE) & grant==N. Ready may depend on valid; valid must not depend on ready.
  - On accept (valid & ready): latch a/b/op into `alu_a`/`alu_b`/`alu_ctrl`, latch `tag`=N, go to EXEC.
- EXEC: exactly one cycle. ALU settles combinationally. At the clock edge, capture `alu_res` → `rsp_result` and `alu_zero` → `rsp_zero`, then go to RESP.
- RESP:
  - `rspN_valid` = (tag==N). The other channel's valid stays 0.
  - `rsp_result`/`rsp_zero` hold stable until the handshake.
  - On `rspN_ready`, return to IDLE. Stall indefinitely otherwise.
- `alu_a`/`alu_b`/`alu_ctrl` hold their last value outside EXEC. They are not cleared.
- Op codes pass through unchecked. Undefined codes produce whatever the ALU default yields (AND).
- Arbitration register `last` (1 bit) updates on every accept to the granted index.
- Width: no arithmetic in this block. Results are carried at WIDTH bits unchanged, and SUB wrap-around is the ALU's.

## Timing
- Accept at edge T0. ALU driven during cycle T0→T1. Result captured at T1. `rsp_valid` is high from T1 until the response handshake.
- Minimum throughput: one op per 3 cycles (accept, EXEC, RESP-with-ready). There is no bypass and no overlap.
- Reset values:
  - `alu_a`/`alu_b` = 0, `alu_ctrl` = 0.
  - `rsp_result` = 0, `rsp_zero` = 0.
  - `rsp0/1_valid` = 0, `busy` = 0.
  - state = IDLE, `last` = 1, `tag` = 0.
- `req0/1_ready` are forced to 0 while `rst_n` is low.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped and no response is issued. After deassertion, the block is in IDLE with the reset values above.
- A request valid that is held during RESP is not accepted until the cycle after the block returns to IDLE.
- Simultaneous valids in IDLE are resolved per Configuration. Exactly one grant per accept.

## Configuration
- `ALU_ARB_RR_EN` defined:
  - Round-robin. With both valid, grant = ~`last`. With one valid, grant that one.
  - Reset `last`=1, so requester 0 wins the first tie.
- Not defined:
  - Fixed priority: requester 0 always wins ties.
  - `last` is still kept but unused for the grant.

## Test plan
- Req0 `` `ALU_ADD `` a=5, b=7, `rsp0_ready`=1 → `rsp0_valid` one cycle after accept, `rsp_result`=12, `rsp_zero`=0, `rsp1_valid`=0.
- Req1 `` `ALU_SUB `` a=9, b=9 → `rsp1_valid` with `rsp_result`=0 and `rsp_zero`=1. Repeat with a=0, b=1 → `rsp_result`=all ones (wrap-around).
- Both valid continuously, each op `` `ALU_ORR `` with distinct operands:
  - With `ALU_ARB_RR_EN`: grants alternate 0,1,0,1.
  - Without it: only requester 0 is served while its valid stays high.
- `rsp0_ready` held low for 5 cycles after a `` `ALU_PASS `` b=0xA5 → `rsp0_valid` and `rsp_result`=0xA5 held stable, both `reqN_ready`=0, `busy`=1. The handshake on the 6th cycle returns the block to IDLE.
- `rst_n` pulsed low during EXEC → no `rsp_valid` ever for that op, and all outputs return to their reset values. The next request completes normally.
- Undefined op 4'hF with a=0xF0, b=0x3C → `rsp_result`=0x30 (ALU default AND).

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two
// requesters. One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
// Optional feature macro: ALU_ARB_RR_EN selects round-robin tie-breaking;
// without it requester 0 has fixed priority on ties.
//
// Handshake rule for every channel here: a transfer happens on a rising edge
// where valid & ready are both high. Ready may look at valid; valid never
// looks at ready. A valid, once raised, is held with stable payload until
// its transfer.

`ifndef WORD
`define WORD 32
`endif

module alu_share_arbiter #(
   parameter int WIDTH = `WORD
) (
   input  logic             clk,
   input  logic             rst_n,
   // requester 0
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,
   // requester 1
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,
   // responses
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   // ALU side
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_zero,
   // status / debug
   output logic             busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             tag_q, tag_d;
   logic             last_q, last_d;

   logic             grant;
   logic             accept;
   logic             rsp_done;

   // Grant selection from the request valids (only meaningful in IDLE).
   always_comb begin
      grant = 1'b0;
`ifdef ALU_ARB_RR_EN
      if (req0_valid && req1_valid) begin
         grant = ~last_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
`else
      if (!req0_valid && req1_valid) begin
         grant = 1'b1;
      end
`endif
   end

   // Ready is held low during reset so nothing is taken while the block is cleared.
   assign req0_ready = rst_n & (state_q == IDLE) & ~grant;
   assign req1_ready = rst_n & (state_q == IDLE) &  grant;
   assign accept     = grant ? (req1_valid & req1_ready) : (req0_valid & req0_ready);
   assign rsp_done   = tag_q ? rsp1_ready : rsp0_ready;

   // Next-state and datapath capture logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      result_d = result_q;
      zero_d   = zero_q;
      tag_d    = tag_q;
      last_d   = last_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d     = grant ? req1_a  : req0_a;
               b_d     = grant ? req1_b  : req0_b;
               ctrl_d  = grant ? req1_op : req0_op;
               tag_d   = grant;
               last_d  = grant;
               state_d = EXEC;
            end
         end
         EXEC: begin
            // ALU output has settled from the registered operands by now.
            result_d = alu_res;
            zero_d   = alu_zero;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         tag_q    <= 1'b0;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         tag_q    <= tag_d;
         last_q   <= last_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_ctrl   = ctrl_q;
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp0_valid = (state_q == RESP) & ~tag_q;
   assign rsp1_valid = (state_q == RESP) &  tag_q;
   assign busy       = (state_q != IDLE);
   assign dbg_state  = state_q;

endmodule
